// File: rtl/latex_uart_pkg.sv
// Shared types and constants for the LaTeX text UART transmitter.
// LATEX_UART_PARITY_EN adds the even-parity state and bit.
package latex_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
`ifdef LATEX_UART_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif
  // Start + data + optional parity + stop, in bit periods.
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef LATEX_UART_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/latex_char_fifo.sv
// Synchronous byte FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module latex_char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign empty_o = (level_q == '0);
  // Guards come from registered state only, so a pop never frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push != do_pop) begin
        level_q <= do_push ? level_q + LevelW'(1) : level_q - LevelW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/latex_uart_tx.sv
// UART transmitter for LaTeX text bytes: FIFO-buffered, LSB-first 8N1 on a single pin.
// Define LATEX_UART_PARITY_EN to send an even-parity bit between data and stop (8E1).
module latex_uart_tx
  import latex_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LevelW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BaudMax = 16'(CLK_DIV - 1);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
`ifdef LATEX_UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_data;
  logic [LevelW-1:0] level_next;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  latex_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (push),
    .wr_data_i (in_data),
    .pop_i     (pop),
    .rd_data_o (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef LATEX_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StStart: begin
        if (baud_q == '0) begin
          state_d   = StData;
          baud_d    = BaudMax;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d = BaudMax;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef LATEX_UART_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef LATEX_UART_PARITY_EN
      StParity: begin
        if (baud_q == '0) begin
          state_d = StStop;
          baud_d  = BaudMax;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      StStop: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when more text is queued.
          if (!fifo_empty) pop = 1'b1;
          else             state_d = StIdle;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d = StStart;
      baud_d  = BaudMax;
      shift_d = fifo_data;
      tx_d    = 1'b0;
`ifdef LATEX_UART_PARITY_EN
      parity_d = ^fifo_data;
`endif
    end
  end

  // Busy is registered, so it looks at the occupancy the FIFO will hold after this edge.
  assign level_next = fifo_level + LevelW'(push) - LevelW'(pop);
  assign busy_d     = (state_d != StIdle) || (level_next != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef LATEX_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef LATEX_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_latex_uart_tx.sv
// Directed bench for latex_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Also compiles with LATEX_UART_PARITY_EN defined, adding the parity scenario.
module tb_latex_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef LATEX_UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] FRAME_5C = 11'b10010111000;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] FRAME_5C = 10'b1010111000;
`endif
  localparam int FL = NB * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  latex_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
    logic [NB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef LATEX_UART_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the start bit, then samples every bit at its centre.
  task automatic recv_frame(output logic [NB-1:0] bits, output int wait_n, output int t_fall);
    bits   = '1;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (tx !== 1'b0 && wait_n < 1000);
    t_fall = cyc;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL recv_timeout: tx=%b after %0d cycles, required 0", tx, wait_n);
    end
    repeat (2) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < NB; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      bits[i] = tx;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || tx !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single();
    logic [NB-1:0] rx;
    int w, t0;
    wait_idle();
    push_byte(8'h5C);
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_early: got %b, required 1", tx); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
    if (fifo_level !== 3'd1) begin
      errors++; $display("FAIL single_level: got %0d, required 1", fifo_level);
    end
    recv_frame(rx, w, t0);
    checks += 2;
    if (w !== 1) begin errors++; $display("FAIL single_latency: got %0d, required 1", w); end
    if (rx !== FRAME_5C) begin
      errors++; $display("FAIL single_frame: got %b, required %b", rx, FRAME_5C);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b, required 1", busy); end
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b, required 0", busy); end
    if (cyc - t0 !== FL) begin
      errors++; $display("FAIL single_frame_len: got %0d, required %0d", cyc - t0, FL);
    end
  endtask

  task automatic test_burst();
    logic [7:0] str [5];
    int t_first = 0;
    str[0] = 8'h5C; str[1] = 8'h66; str[2] = 8'h72; str[3] = 8'h61; str[4] = 8'h63;
    wait_idle();
    fork
      begin
        int n = 0;
        for (int i = 0; i < 5; i++) push_byte(str[i]);
        checks += 2;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL burst_full_ready: got %b, required 0", in_ready);
        end
        if (fifo_level !== 3'd4) begin
          errors++; $display("FAIL burst_full_level: got %0d, required 4", fifo_level);
        end
        while (in_ready !== 1'b1 && n < 500) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n !== FL - 3) begin
          errors++; $display("FAIL burst_ready_rise: got %0d cycles, required %0d", n, FL - 3);
        end
      end
      begin
        logic [NB-1:0] rx;
        int w, t;
        for (int i = 0; i < 5; i++) begin
          recv_frame(rx, w, t);
          if (i == 0) t_first = t;
          checks += 2;
          if (rx !== frame_of(str[i])) begin
            errors++;
            $display("FAIL burst_char%0d: got %b, required %b", i, rx, frame_of(str[i]));
          end
          if (w !== 2) begin errors++; $display("FAIL burst_gap%0d: got %0d, required 2", i, w); end
        end
      end
    join
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_drop: got %b, required 0", busy); end
    if (cyc - t_first !== 5 * FL) begin
      errors++; $display("FAIL burst_len: got %0d, required %0d", cyc - t_first, 5 * FL);
    end
  endtask

  task automatic test_fifo_wrap();
    logic [7:0] seq [9];
    seq[0] = 8'h65; seq[1] = 8'h5E; seq[2] = 8'h7B; seq[3] = 8'h2D; seq[4] = 8'h73;
    seq[5] = 8'h74; seq[6] = 8'h7D; seq[7] = 8'h64; seq[8] = 8'h74;
    wait_idle();
    fork
      begin
        for (int i = 0; i < 3; i++) push_byte(seq[i]);
        checks++;
        if (fifo_level !== 3'd2) begin
          errors++; $display("FAIL fifo_level_pre: got %0d, required 2", fifo_level);
        end
        // Line up the next push with the pop at the end of the first frame.
        repeat (FL - 2) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd2) begin
          errors++; $display("FAIL fifo_level_hold: got %0d, required 2", fifo_level);
        end
        in_data  = seq[3];
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd2) begin
          errors++; $display("FAIL fifo_push_pop: got %0d, required 2", fifo_level);
        end
        for (int i = 4; i < 9; i++) push_byte(seq[i]);
      end
      begin
        logic [NB-1:0] rx;
        int w, t;
        for (int i = 0; i < 9; i++) begin
          recv_frame(rx, w, t);
          checks += 2;
          if (rx !== frame_of(seq[i])) begin
            errors++;
            $display("FAIL wrap_char%0d: got %b, required %b", i, rx, frame_of(seq[i]));
          end
          if (w !== 2) begin errors++; $display("FAIL wrap_gap%0d: got %0d, required 2", i, w); end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [NB-1:0] rx;
    int w, t, lows;
    wait_idle();
    push_byte(8'h41);
    push_byte(8'h42);
    repeat (14) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_data_bit2: got %b, required 0", tx); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b, required 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_reset_level: got %0d, required 0", fifo_level);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks += 2;
    if (lows !== 0) begin errors++; $display("FAIL mid_after_release: got %0d low samples, required 0", lows); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy: got %b, required 0", busy); end
    push_byte(8'h28);
    recv_frame(rx, w, t);
    checks += 2;
    if (w !== 1) begin errors++; $display("FAIL mid_next_latency: got %0d, required 1", w); end
    if (rx !== frame_of(8'h28)) begin
      errors++; $display("FAIL mid_next_frame: got %b, required %b", rx, frame_of(8'h28));
    end
  endtask

`ifdef LATEX_UART_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] rx;
    int w, t0;
    wait_idle();
    push_byte(8'h73);
    recv_frame(rx, w, t0);
    checks += 2;
    if (rx !== 11'b11011100110) begin
      errors++; $display("FAIL parity_73_frame: got %b, required 11011100110", rx);
    end
    if (rx[9] !== 1'b1) begin errors++; $display("FAIL parity_73_bit: got %b, required 1", rx[9]); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cyc - t0 !== 44) begin
      errors++; $display("FAIL parity_len: busy=%b len=%0d, required busy=0 len=44", busy, cyc - t0);
    end
    wait_idle();
    push_byte(8'h41);
    recv_frame(rx, w, t0);
    checks += 2;
    if (rx !== 11'b10010000010) begin
      errors++; $display("FAIL parity_41_frame: got %b, required 10010000010", rx);
    end
    if (rx[9] !== 1'b0) begin errors++; $display("FAIL parity_41_bit: got %b, required 0", rx[9]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fifo_wrap();
    test_reset_mid_frame();
`ifdef LATEX_UART_PARITY_EN
    test_parity();
`endif
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
